seg7_scan_driver: RTL and testbench

Sequential display back end for the 8-bit computer. It consumes the ALU result byte and converts it to decimal with an iterative double-dabble engine; the input can be read as unsigned or as two's complement. It then time-multiplexes the three decimal digits and a sign position onto the 4-digit active-low 7-segment display. It replaces the combinational BCD and display multiplexing in `computer` with a registered, glitch-free path that can be reset.

---
 rtl/seg7_scan_driver.sv | 230 +++++++++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Registered byte-to-decimal display back end: iterative double-dabble conversion
// feeding a time-multiplexed, active-low 4-digit 7-segment scanner.
module seg7_scan_driver #(
    parameter int DIV   = 50000,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       signed_mode,
    input  logic       load,
    output logic       busy,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam int            PW         = $clog2(DIV + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ACTIVE_END = PW'(DIV - BLANK);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SHIFT  = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [6:0] GLYPH_MINUS = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = 7'b1000000;
            4'd1:    g = 7'b1111001;
            4'd2:    g = 7'b0100100;
            4'd3:    g = 7'b0110000;
            4'd4:    g = 7'b0011001;
            4'd5:    g = 7'b0010010;
            4'd6:    g = 7'b0000010;
            4'd7:    g = 7'b1111000;
            4'd8:    g = 7'b0000000;
            4'd9:    g = 7'b0010000;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] n);
        logic [3:0] r;
        if (n >= 4'd5) begin
            r = n + 4'd3;
        end else begin
            r = n;
        end
        return r;
    endfunction

    // Returns {neg, magnitude}; 0x80 signed yields magnitude 128.
    function automatic logic [8:0] capture(input logic [7:0] v, input logic sm);
        logic neg;
        neg = sm & v[7];
        if (neg) begin
            capture = {1'b1, ~v + 8'd1};
        end else begin
            capture = {1'b0, v};
        end
    endfunction

    logic [1:0]    state_q, state_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [11:0]   scratch_q, scratch_d;
    logic [7:0]    mag_q, mag_d;
    logic          neg_cap_q, neg_cap_d;
    logic          pend_q, pend_d;
    logic [7:0]    pend_val_q, pend_val_d;
    logic          pend_sm_q, pend_sm_d;
    logic [3:0]    disp_h_q, disp_h_d;
    logic [3:0]    disp_t_q, disp_t_d;
    logic [3:0]    disp_o_q, disp_o_d;
    logic          disp_neg_q, disp_neg_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic [11:0]   adj_s;

    // Conversion FSM, pending-request slot and display register update.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        scratch_d  = scratch_q;
        mag_d      = mag_q;
        neg_cap_d  = neg_cap_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_sm_d  = pend_sm_q;
        disp_h_d   = disp_h_q;
        disp_t_d   = disp_t_q;
        disp_o_d   = disp_o_q;
        disp_neg_d = disp_neg_q;
        adj_s      = {add3(scratch_q[11:8]), add3(scratch_q[7:4]), add3(scratch_q[3:0])};
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    {neg_cap_d, mag_d} = capture(value, signed_mode);
                    scratch_d = 12'd0;
                    cnt_d     = 3'd0;
                    state_d   = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                scratch_d = {adj_s[10:0], mag_q[7]};
                mag_d     = {mag_q[6:0], 1'b0};
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_COMMIT;
                end else begin
                    state_d = S_SHIFT;
                end
                if (load) begin
                    pend_d     = 1'b1;
                    pend_val_d = value;
                    pend_sm_d  = signed_mode;
                end else begin
                    pend_d = pend_q;
                end
            end
            S_COMMIT: begin
                disp_h_d   = scratch_q[11:8];
                disp_t_d   = scratch_q[7:4];
                disp_o_d   = scratch_q[3:0];
                disp_neg_d = neg_cap_q;
                // A live request is newer than anything held in the pending slot.
                if (load) begin
                    {neg_cap_d, mag_d} = capture(value, signed_mode);
                    scratch_d = 12'd0;
                    cnt_d     = 3'd0;
                    pend_d    = 1'b0;
                    state_d   = S_SHIFT;
                end else if (pend_q) begin
                    {neg_cap_d, mag_d} = capture(pend_val_q, pend_sm_q);
                    scratch_d = 12'd0;
                    cnt_d     = 3'd0;
                    pend_d    = 1'b0;
                    state_d   = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // Prescaler, digit index and registered anode/segment drive.
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        an_d    = 4'b1111;
        seg_d   = GLYPH_BLANK;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end else begin
            idx_d = idx_q;
        end
        if (presc_q < ACTIVE_END) begin
            an_d = ~(4'b0001 << idx_q);
        end else begin
            an_d = 4'b1111;
        end
        case (idx_q)
            2'd0: seg_d = digit_glyph(disp_o_q);
            2'd1: seg_d = ((disp_h_q == 4'd0) && (disp_t_q == 4'd0)) ? GLYPH_BLANK : digit_glyph(disp_t_q);
            2'd2: seg_d = (disp_h_q == 4'd0) ? GLYPH_BLANK : digit_glyph(disp_h_q);
            2'd3: seg_d = disp_neg_q ? GLYPH_MINUS : GLYPH_BLANK;
            default: seg_d = GLYPH_BLANK;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            scratch_q  <= 12'd0;
            mag_q      <= 8'd0;
            neg_cap_q  <= 1'b0;
            pend_q     <= 1'b0;
            pend_val_q <= 8'd0;
            pend_sm_q  <= 1'b0;
            disp_h_q   <= 4'd0;
            disp_t_q   <= 4'd0;
            disp_o_q   <= 4'd0;
            disp_neg_q <= 1'b0;
            busy_q     <= 1'b0;
            presc_q    <= '0;
            idx_q      <= 2'd0;
            an_q       <= 4'b1111;
            seg_q      <= GLYPH_BLANK;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            scratch_q  <= scratch_d;
            mag_q      <= mag_d;
            neg_cap_q  <= neg_cap_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_sm_q  <= pend_sm_d;
            disp_h_q   <= disp_h_d;
            disp_t_q   <= disp_t_d;
            disp_o_q   <= disp_o_d;
            disp_neg_q <= disp_neg_d;
            busy_q     <= busy_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign busy = busy_q;
    assign an   = an_q;
    assign seg  = seg_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a request-level model queues expected
// display contents; a monitor checks every scanned digit, anode and busy.
module tb_seg7_scan_driver;
    localparam int DIV   = 4;
    localparam int BLANK = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'd0;
    logic       signed_mode = 1'b0;
    logic       load = 1'b0;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    seg7_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk(clk), .rst(rst), .value(value), .signed_mode(signed_mode),
        .load(load), .busy(busy), .an(an), .seg(seg)
    );

    logic [6:0] digits [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    localparam logic [6:0] G_MINUS = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef struct { int at; logic [27:0] g; } exp_t;
    exp_t exp_q[$];
    exp_t cur;

    int checks = 0;
    int errors = 0;

    // Request-level model state
    int         edge_n = 0;
    int         n_since = 0;
    bit         started = 0;
    bit         rst_seen = 0;
    bit         active = 0;
    int         cm = 0;
    logic [7:0] cur_v;
    logic       cur_sm;
    bit         pend = 0;
    logic [7:0] pend_v;
    logic       pend_sm;
    bit         busy_exp = 0;

    // Decimal rendering straight from the display rules, glyphs packed digit 0 in [6:0].
    function automatic logic [27:0] render(input logic [7:0] v, input logic sm);
        logic [27:0] r;
        bit neg;
        int mag, h, t, o;
        neg = sm && v[7];
        mag = neg ? 256 - int'(v) : int'(v);
        h = mag / 100;
        t = (mag / 10) % 10;
        o = mag % 10;
        r[6:0]   = digits[o];
        r[13:7]  = (h == 0 && t == 0) ? G_BLANK : digits[t];
        r[20:14] = (h == 0) ? G_BLANK : digits[h];
        r[27:21] = neg ? G_MINUS : G_BLANK;
        return r;
    endfunction

    task automatic start_conv(input logic [7:0] v, input logic s);
        active = 1;
        cm     = edge_n + 9;
        cur_v  = v;
        cur_sm = s;
    endtask

    task automatic model_edge();
        exp_t e;
        edge_n++;
        started = 1;
        if (rst) begin
            rst_seen = 1;
            n_since  = 0;
            active   = 0;
            pend     = 0;
            busy_exp = 0;
            exp_q.delete();
            e.at = edge_n;
            e.g  = render(8'd0, 1'b0);
            exp_q.push_back(e);
        end else begin
            rst_seen = 0;
            n_since++;
            if (active && edge_n == cm) begin
                e.at = edge_n;
                e.g  = render(cur_v, cur_sm);
                exp_q.push_back(e);
                if (load) begin
                    start_conv(value, signed_mode);
                    pend = 0;
                end else if (pend) begin
                    start_conv(pend_v, pend_sm);
                    pend = 0;
                end else begin
                    active = 0;
                end
            end else if (active) begin
                if (load) begin
                    pend    = 1;
                    pend_v  = value;
                    pend_sm = signed_mode;
                end
            end else if (load) begin
                start_conv(value, signed_mode);
            end
            busy_exp = active;
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [7:0] v, input bit s);
        rst         = r;
        load        = ld;
        value       = ld ? v : 8'($urandom);
        signed_mode = s;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'd0, 1'($urandom));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s edge=%0d got %h expected %h", name, edge_n, got, exp);
        end
    endtask

    // Monitor: pops committed displays once they reach the outputs and checks every cycle.
    initial begin
        int p, d;
        logic [3:0] ea;
        forever begin
            @(negedge clk);
            if (started) begin
                while (exp_q.size() > 0 && exp_q[0].at < edge_n) cur = exp_q.pop_front();
                if (rst_seen) begin
                    check("an_rst", 32'(an), 32'hF);
                    check("seg_rst", 32'(seg), 32'h7F);
                    check("busy_rst", 32'(busy), 32'h0);
                end else begin
                    p  = (n_since - 1) % DIV;
                    d  = ((n_since - 1) / DIV) % 4;
                    ea = 4'hF;
                    if (p < DIV - BLANK) ea[d] = 1'b0;
                    check("an", 32'(an), 32'(ea));
                    if (ea != 4'hF) check($sformatf("seg_d%0d", d), 32'(seg), 32'(cur.g[d*7 +: 7]));
                    check("busy", 32'(busy), 32'(busy_exp));
                end
            end
        end
    end

    initial begin
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 8'hFF, 1'b0); idle(44);
        step(1'b0, 1'b1, 8'h80, 1'b1); idle(44);
        step(1'b0, 1'b1, 8'hFF, 1'b1); idle(44);
        step(1'b0, 1'b1, 8'h7F, 1'b1); idle(44);
        // Overlapping requests: 10 is superseded by 20 while 7 converts.
        step(1'b0, 1'b1, 8'd7, 1'b0);
        idle(1);
        step(1'b0, 1'b1, 8'd10, 1'b0);
        step(1'b0, 1'b1, 8'd20, 1'b0);
        idle(50);
        // Reset four edges into a conversion of 200.
        step(1'b0, 1'b1, 8'd200, 1'b0);
        idle(3);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 8'd42, 1'b0); idle(44);
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 1'b1, 8'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, 12)));
        end
        idle(70);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
